// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Brief    : Shared types and helpers for the external interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int NSRC_MAX = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } irq_state_t;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic int unsigned lowestSet(input logic [NSRC_MAX-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = NSRC_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ext_irq_ctrl_if
// Brief    : Interrupt sources, mask and processor request/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface ext_irq_ctrl_if #(
    parameter int NSRC = 4
);
    localparam int IDW = $clog2(NSRC);

    logic [NSRC-1:0] irq_src;
    logic [NSRC-1:0] irq_mask;
    logic            ExtIAck;
    logic            ExtIRQ;
    logic [IDW-1:0]  irq_id;
    logic [NSRC-1:0] pending;

    // master: the controller; slave: processor plus interrupt sources
    modport master (
        input  irq_src,
        input  irq_mask,
        input  ExtIAck,
        output ExtIRQ,
        output irq_id,
        output pending
    );

    modport slave (
        output irq_src,
        output irq_mask,
        output ExtIAck,
        input  ExtIRQ,
        input  irq_id,
        input  pending
    );

endinterface
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_edge
// Brief    : Multi-flop synchronizer followed by a rising-edge pulse detector.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic CLOCK_50,
    input  wire logic reset,
    input  wire logic d,
    output logic      edge_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_syncD;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_syncD <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], d};
            r_syncD <= r_sync[SYNC_STAGES-1];
        end
    end

    assign edge_o = r_sync[SYNC_STAGES-1] & ~r_syncD;

endmodule
`default_nettype wire

// File: rtl/ext_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ext_irq_ctrl
// Brief    : Edge-latching, fixed-priority interrupt controller with a
//            four-phase ExtIRQ/ExtIAck handshake towards the processor.
// Revision : 1.0 - initial release
// ============================================================================
module ext_irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic      CLOCK_50,
    input  wire logic      reset,
    ext_irq_ctrl_if.master irqBus
);

    localparam int IDW = $clog2(NSRC);

    irq_state_t          r_state;
    logic                r_extIrq;
    logic [IDW-1:0]      r_irqId;
    logic [NSRC-1:0]     r_pending;

    logic [NSRC-1:0]     w_edge;
    logic [NSRC-1:0]     w_clr;
    logic [NSRC_MAX-1:0] w_reqVec;
    logic [IDW-1:0]      w_winner;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_syncEdge (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .d        (irqBus.irq_src[gi]),
                .edge_o   (w_edge[gi])
            );
        end
    endgenerate

    assign w_reqVec = NSRC_MAX'(r_pending & irqBus.irq_mask);
    assign w_winner = IDW'(lowestSet(w_reqVec));

    // The clear targets the committed id, not the current winner.
    assign w_clr = (r_state == REQ && irqBus.ExtIAck) ? (NSRC'(1) << r_irqId) : '0;

    // A new edge on the source being cleared re-pends it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_extIrq <= 1'b0;
            r_irqId  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_extIrq <= 1'b0;
                    if (irqBus.ExtIAck) begin
                        r_state <= WAIT_LOW;
                    end else if (|w_reqVec) begin
                        r_irqId  <= w_winner;
                        r_extIrq <= 1'b1;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    if (irqBus.ExtIAck) begin
                        r_extIrq <= 1'b0;
                        r_state  <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    r_extIrq <= 1'b0;
                    if (!irqBus.ExtIAck) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_extIrq <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign irqBus.ExtIRQ  = r_extIrq;
    assign irqBus.irq_id  = r_irqId;
    assign irqBus.pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_ext_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_irq_ctrl
// Brief    : Directed self-checking bench for ext_irq_ctrl (NSRC=4, 2 stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_irq_ctrl;

    logic clk;
    logic rst;
    int   nTotal;
    int   nBad;

    ext_irq_ctrl_if #(.NSRC(4)) irqBus ();

    ext_irq_ctrl #(
        .NSRC        (4),
        .SYNC_STAGES (2)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .irqBus   (irqBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic sawIrq;
        int   nReq;
        nTotal = 0;
        nBad   = 0;
        rst = 1'b1;
        irqBus.irq_src  = 4'b0000;
        irqBus.irq_mask = 4'b1111;
        irqBus.ExtIAck  = 1'b0;
        ticks(3);
        rst = 1'b0;
        tick();
        chkEq("rst_irq",  32'(irqBus.ExtIRQ),  32'd0);
        chkEq("rst_pend", 32'(irqBus.pending), 32'd0);
        chkEq("rst_id",   32'(irqBus.irq_id),  32'd0);

        // single source 2: pending after edge 2, request after edge 3
        irqBus.irq_src = 4'b0100;
        ticks(2);
        chkEq("s_pend_e1", 32'(irqBus.pending), 32'h0);
        tick();
        chkEq("s_pend_e2", 32'(irqBus.pending), 32'h4);
        chkEq("s_irq_e2",  32'(irqBus.ExtIRQ),  32'd0);
        tick();
        chkEq("s_irq_e3",  32'(irqBus.ExtIRQ),  32'd1);
        chkEq("s_id_e3",   32'(irqBus.irq_id),  32'd2);
        ticks(2);
        chkEq("s_irq_hold", 32'(irqBus.ExtIRQ), 32'd1);
        irqBus.ExtIAck = 1'b1;
        tick();
        chkEq("s_irq_ack",  32'(irqBus.ExtIRQ),  32'd0);
        chkEq("s_pend_ack", 32'(irqBus.pending), 32'h0);
        irqBus.ExtIAck = 1'b0;
        irqBus.irq_src = 4'b0000;
        ticks(5);
        chkEq("s_idle", 32'(irqBus.ExtIRQ), 32'd0);

        // priority: sources 3 and 1 together
        irqBus.irq_src = 4'b1010;
        ticks(3);
        chkEq("p_pend", 32'(irqBus.pending), 32'ha);
        tick();
        chkEq("p_irq1", 32'(irqBus.ExtIRQ), 32'd1);
        chkEq("p_id1",  32'(irqBus.irq_id), 32'd1);
        irqBus.ExtIAck = 1'b1;
        tick();
        chkEq("p_pend_ack", 32'(irqBus.pending), 32'h8);
        irqBus.ExtIAck = 1'b0;
        tick();
        chkEq("p_gap", 32'(irqBus.ExtIRQ), 32'd0);
        tick();
        chkEq("p_irq3", 32'(irqBus.ExtIRQ), 32'd1);
        chkEq("p_id3",  32'(irqBus.irq_id), 32'd3);
        irqBus.ExtIAck = 1'b1;
        tick();
        irqBus.ExtIAck = 1'b0;
        irqBus.irq_src = 4'b0000;
        ticks(5);

        // masked source 0 stays pending until unmasked
        irqBus.irq_mask = 4'b1110;
        irqBus.irq_src  = 4'b0001;
        ticks(3);
        chkEq("m_pend", 32'(irqBus.pending), 32'h1);
        sawIrq = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sawIrq = sawIrq | irqBus.ExtIRQ;
        end
        chkEq("m_quiet", 32'(sawIrq), 32'd0);
        irqBus.irq_mask = 4'b1111;
        tick();
        chkEq("m_irq", 32'(irqBus.ExtIRQ), 32'd1);
        chkEq("m_id",  32'(irqBus.irq_id), 32'd0);
        irqBus.ExtIAck = 1'b1;
        tick();
        irqBus.ExtIAck = 1'b0;
        irqBus.irq_src = 4'b0000;
        ticks(5);

        // level held high for 50 cycles gives one request
        irqBus.irq_src = 4'b0010;
        nReq = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (irqBus.ExtIRQ && !irqBus.ExtIAck) begin
                nReq++;
                irqBus.ExtIAck = 1'b1;
            end else begin
                irqBus.ExtIAck = 1'b0;
            end
        end
        irqBus.ExtIAck = 1'b0;
        chkEq("l_nreq", 32'(nReq), 32'd1);
        chkEq("l_pend", 32'(irqBus.pending), 32'h0);
        irqBus.irq_src = 4'b0000;
        ticks(5);

        // set-wins: second edge of source 1 lands on the ack edge (E6)
        irqBus.irq_src = 4'b0010;
        tick();
        irqBus.irq_src = 4'b0000;
        ticks(2);
        chkEq("sw_pend", 32'(irqBus.pending), 32'h2);
        tick();
        chkEq("sw_irq", 32'(irqBus.ExtIRQ), 32'd1);
        chkEq("sw_id",  32'(irqBus.irq_id), 32'd1);
        irqBus.irq_src = 4'b0010;
        ticks(2);
        irqBus.ExtIAck = 1'b1;
        tick();
        chkEq("sw_irq_ack",  32'(irqBus.ExtIRQ),  32'd0);
        chkEq("sw_pend_ack", 32'(irqBus.pending), 32'h2);
        irqBus.ExtIAck = 1'b0;
        tick();
        chkEq("sw_gap", 32'(irqBus.ExtIRQ), 32'd0);
        tick();
        chkEq("sw_irq2", 32'(irqBus.ExtIRQ), 32'd1);
        chkEq("sw_id2",  32'(irqBus.irq_id), 32'd1);

        // stuck ack for 10 cycles with source 2 pending
        irqBus.ExtIAck = 1'b1;
        tick();
        irqBus.irq_src = 4'b0100;
        sawIrq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            sawIrq = sawIrq | irqBus.ExtIRQ;
        end
        chkEq("k_quiet", 32'(sawIrq), 32'd0);
        chkEq("k_pend",  32'(irqBus.pending), 32'h4);
        irqBus.ExtIAck = 1'b0;
        tick();
        chkEq("k_gap", 32'(irqBus.ExtIRQ), 32'd0);
        tick();
        chkEq("k_irq", 32'(irqBus.ExtIRQ), 32'd1);
        chkEq("k_id",  32'(irqBus.irq_id), 32'd2);
        irqBus.ExtIAck = 1'b1;
        tick();
        irqBus.ExtIAck = 1'b0;
        ticks(2);

        // ack already high in IDLE blocks a new request
        irqBus.ExtIAck = 1'b1;
        tick();
        irqBus.irq_src = 4'b1100;
        sawIrq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            sawIrq = sawIrq | irqBus.ExtIRQ;
        end
        chkEq("i_quiet", 32'(sawIrq), 32'd0);
        irqBus.ExtIAck = 1'b0;
        ticks(2);
        chkEq("i_irq", 32'(irqBus.ExtIRQ), 32'd1);
        chkEq("i_id",  32'(irqBus.irq_id), 32'd3);

        // asynchronous reset in the middle of REQ
        irqBus.irq_src = 4'b0000;
        rst = 1'b1;
        #1;
        chkEq("ar_irq",  32'(irqBus.ExtIRQ),  32'd0);
        chkEq("ar_pend", 32'(irqBus.pending), 32'h0);
        chkEq("ar_id",   32'(irqBus.irq_id),  32'd0);
        tick();
        rst = 1'b0;
        sawIrq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            sawIrq = sawIrq | irqBus.ExtIRQ;
        end
        chkEq("ar_quiet", 32'(sawIrq), 32'd0);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- External interrupt controller placed directly upstream of the processor top level.
- Collects NSRC asynchronous interrupt lines, synchronizes them and latches rising edges into a pending register.
- Selects the highest-priority unmasked pending source, drives the single-wire ExtIRQ request and completes a four-phase handshake on ExtIAck.
- Exposes the serviced source id and the pending vector so the exception handler can identify the cause.

Parameters:
- NSRC, 4, number of interrupt sources (2..16).
- SYNC_STAGES, 2, synchronizer flops per source (>=2).
- IDW, $clog2(NSRC), width of irq_id (derived; not overridden).

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_src  in  NSRC  raw asynchronous interrupt lines, rising-edge triggered.
- irq_mask  in  NSRC  1 = source enabled; synchronous to CLOCK_50.
- ExtIAck  in  1  acknowledge from processor, level.
- ExtIRQ  out  1  interrupt request to processor.
- irq_id  out  IDW  index of the source currently requested/being acknowledged.
- pending  out  NSRC  latched pending edges, regardless of mask.

Behaviour:
- Async reset: ExtIRQ=0, irq_id=0, pending=0, all sync/edge flops=0, FSM=IDLE. Reset mid-handshake abandons the request; the pending edge is lost.
- Per source: SYNC_STAGES-flop synchronizer, then edge flop; edge[i] = sync[i] & ~sync_d[i] (one-cycle pulse).
- A pending[i] set at edge k is caused by the edge[i] pulse at k. A high irq_src held indefinitely produces exactly one pulse. Re-triggering requires a low level for at least SYNC_STAGES+1 cycles.
- Latency (SYNC_STAGES=2, idle, unmasked): irq_src high before edge 0 -> pending[i]=1 after edge 2 -> ExtIRQ=1 after edge 3.
- Priority: lowest index wins among (pending & irq_mask).
- FSM states (enum in package):
  - IDLE: ExtIRQ=0. If |(pending & irq_mask), latch irq_id = winner and go to REQ.
  - REQ: ExtIRQ=1; irq_id is held stable. On ExtIAck=1, clear pending[irq_id] at the same edge, drop ExtIRQ and go to WAIT_LOW.
  - WAIT_LOW: ExtIRQ=0. Stay until ExtIAck=0, then go to IDLE. A new request never starts while ExtIAck is high.
- ExtIRQ is registered: ExtIRQ = (state==REQ) from a flop, with no combinational path from ExtIAck.
- Same-cycle set and clear of a source: set wins (a new edge arriving on the acked source at the clearing edge re-pends it).
- Masking while in REQ does not withdraw the request; the committed source is still acked and cleared.
- Masked pending bits remain pending and are requested once unmasked.
- A higher-priority edge arriving during REQ does not pre-empt; it is served in the next IDLE pass.
- ExtIAck=1 while in IDLE: ignored, and it blocks entry to REQ (treated as WAIT_LOW until low).
- Minimum spacing between consecutive requests: ExtIRQ low for at least 2 cycles (WAIT_LOW exit + IDLE select).

Decomposition:
- Package irq_pkg: typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} irq_state_t; localparam NSRC_MAX=16.
- Sub-module irq_sync_edge (params SYNC_STAGES; ports CLOCK_50, reset, d, edge_o), generated once per source.
- Priority encoder and FSM live in ext_irq_ctrl.

Test Plan:
- Reset: assert reset mid-REQ -> ExtIRQ=0, pending=0, irq_id=0 immediately (asynchronous); no request after release with irq_src=0.
- Single source, NSRC=4, mask=4'b1111: irq_src[2] rises before edge 0 -> pending=4'b0100 after edge 2, ExtIRQ=1 and irq_id=2 after edge 3. ExtIAck=1 two cycles later -> ExtIRQ=0, pending=0 at the next edge. ExtIAck=0 -> FSM returns to IDLE.
- Priority: edges on sources 3 and 1 in the same cycle -> irq_id=1 first. After the ack completes, irq_id=3 and ExtIRQ re-asserts 2 cycles after ExtIAck falls.
- Mask: mask=4'b1110, edge on source 0 -> pending=4'b0001 and ExtIRQ stays 0 for 20 cycles. Set mask=4'b1111 -> ExtIRQ=1, irq_id=0 one cycle later.
- Level hold and set-wins: irq_src[1] held high for 50 cycles -> exactly one request. Then toggle source 1 low/high timed so its edge pulse coincides with the ack edge -> pending[1] remains 1 and a second request for id 1 follows.
- Stuck ack: hold ExtIAck=1 for 10 cycles after the ack -> ExtIRQ stays 0 throughout, even with source 2 pending. ExtIRQ=1 and irq_id=2 two cycles after ExtIAck falls.
